// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUop encodings and multiply/divide sequencer state.
// The sequencer is only built when RV_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    // Base (funct7[5] = 0) operation for a register or immediate ALU funct3.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with the sign fix applied as the result is registered.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output md_state_t       state,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_res;
    logic              want_hi;
    logic              want_rem;

    logic            is_div, a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = is_div ? ~funct3[0] : ~funct3[1];
        neg_a       = a_signed & op_a[XLEN-1];
        neg_b       = b_signed & op_b[XLEN-1];
        mag_a       = neg_a ? -op_a : op_a;
        mag_b       = neg_b ? -op_b : op_b;
        div_zero    = is_div & (op_b == '0);
        div_ovf     = is_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
        special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo, rem, iter_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
        if (state == DIV) begin
            acc_next = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_res ? -acc_next : acc_next;
        quo      = acc_next[XLEN-1:0];
        rem      = acc_next[2*XLEN-1:XLEN];
        if (state == DIV) begin
            iter_res = want_rem ? (neg_res ? -rem : rem) : (neg_res ? -quo : quo);
        end else begin
            iter_res = want_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_res   <= 1'b0;
            want_hi   <= 1'b0;
            want_rem  <= 1'b0;
            md_done   <= 1'b0;
            md_result <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        cnt      <= '0;
                        neg_res  <= (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
                        want_hi  <= (funct3[1:0] != 2'b00);
                        want_rem <= funct3[1];
                        if (div_zero || div_ovf) begin
                            state     <= DONE;
                            md_done   <= 1'b1;
                            md_result <= special_res;
                        end else if (is_div) begin
                            state <= DIV;
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            opnd  <= mag_b;
                        end else begin
                            state <= MUL;
                            acc   <= {{XLEN{1'b0}}, mag_b};
                            opnd  <= mag_a;
                        end
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state     <= DONE;
                            md_done   <= 1'b1;
                            md_result <= iter_res;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Execute-stage ALU control decoder with an optional RV32M sequencer,
// enabled by defining RV_MULDIV_EN.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [1:0]        ALUop,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [CTRL_W-1:0] ALUcontrol,
    output logic              illegal,
    output logic              md_sel,
    output logic              stall,
    output logic              md_done,
    output logic [XLEN-1:0]   md_result
);

    logic       is_md;
    logic       start;
    logic [3:0] ctl;
    logic       ill;

    // Handshake: the instruction is held in execute while stall is high; it
    // retires on the edge that ends the md_done cycle, and a new one may follow.
    assign is_md = (ALUop == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);
    assign start = valid_in & is_md;

    always_comb begin
        ctl = ALU_ADD;
        ill = 1'b0;
        case (ALUop)
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctl = ALU_SUB;
                    3'b100, 3'b101: ctl = ALU_SLT;
                    3'b110, 3'b111: ctl = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            ALUOP_RTYPE: begin
                if (is_md) begin
`ifdef RV_MULDIV_EN
                    ctl = ALU_ADD;
`else
                    ill = 1'b1;
`endif
                end else if (funct7 == FUNCT7_BASE) begin
                    ctl = base_op(funct3);
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    ctl = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    ctl = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            ALUOP_ITYPE: ctl = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : base_op(funct3);
            default:     ctl = ALU_ADD;
        endcase
    end

    assign ALUcontrol = CTRL_W'(ctl);
    assign illegal    = ill;

`ifdef RV_MULDIV_EN
    md_state_t md_state;

    muldiv_seq #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .state     (md_state),
        .md_done   (md_done),
        .md_result (md_result)
    );

    assign md_sel = is_md;
    assign stall  = (md_state == IDLE && start && !flush) || (md_state == MUL) || (md_state == DIV);
`else
    logic unused_md;
    assign unused_md = ^{clk, rst_n, start, flush, op_a, op_b};

    assign md_sel    = 1'b0;
    assign stall     = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized self-checking bench for alu_ctrl_seq against a behavioural model;
// covers the RV_MULDIV_EN build and the default build.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

    localparam int XLEN = 32;
    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_XOR = 4'd3;
    localparam logic [3:0] C_SLL = 4'd4, C_SRL = 4'd5, C_SUB = 4'd6, C_SRA = 4'd7;
    localparam logic [3:0] C_SLT = 4'd8, C_SLTU = 4'd9;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      alu_op = 2'b00;
    logic [2:0]      funct3 = 3'b000;
    logic [6:0]      funct7 = 7'b0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic [3:0]      alu_control;
    logic            illegal, md_sel, stall, md_done;
    logic [XLEN-1:0] md_result;

    int n_checks = 0;
    int n_pass = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res = '0;
    logic [3:0] r_tab [0:7] = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};

    // Clock / reset
    always #5 clk = ~clk;

    alu_ctrl_seq #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .flush      (flush),
        .ALUop      (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .op_a       (op_a),
        .op_b       (op_b),
        .ALUcontrol (alu_control),
        .illegal    (illegal),
        .md_sel     (md_sel),
        .stall      (stall),
        .md_done    (md_done),
        .md_result  (md_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference decoder written from the instruction table.
    function automatic void dec_model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      output logic [3:0] ctl, output logic ill, output logic sel);
        ctl = C_ADD; ill = 1'b0; sel = 1'b0;
        if (op == 2'd1) begin
            if (f3 == 3'd0 || f3 == 3'd1) ctl = C_SUB;
            else if (f3 == 3'd4 || f3 == 3'd5) ctl = C_SLT;
            else if (f3 == 3'd6 || f3 == 3'd7) ctl = C_SLTU;
            else ill = 1'b1;
        end else if (op == 2'd2) begin
            if (f7 == 7'h01) begin
`ifdef RV_MULDIV_EN
                sel = 1'b1;
`else
                ill = 1'b1;
`endif
            end else if (f7 == 7'h00) ctl = r_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) ctl = C_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) ctl = C_SRA;
            else ill = 1'b1;
        end else if (op == 2'd3) begin
            ctl = (f3 == 3'd5 && f7[5]) ? C_SRA : r_tab[f3];
        end
    endfunction

    task automatic dec_check(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [3:0] exp_ctl, input logic exp_ill, input logic exp_sel);
        valid_in = 1'b0;
        alu_op = op; funct3 = f3; funct7 = f7;
        #1;
        check("alu_control", alu_control, exp_ctl);
        check("illegal", illegal, exp_ill);
        check("md_sel", md_sel, exp_sel);
    endtask

    task automatic dec_random();
        logic [3:0] c; logic il, sl; logic [6:0] f7;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        alu_op = 2'($urandom_range(0, 3));
        funct3 = 3'($urandom_range(0, 7));
        dec_model(alu_op, funct3, f7, c, il, sl);
        dec_check(alu_op, funct3, f7, c, il, sl);
    endtask

    // Reference multiply/divide computed with 64-bit arithmetic.
    function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = $signed(a); sb = $signed(b); ub = longint'({32'b0, b});
        case (f3)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >> 32;
            3'd2: p = (sa * ub) >> 32;
            3'd3: p = ({32'b0, a} * {32'b0, b}) >> 32;
            3'd4: p = (b == 0) ? 64'hFFFF_FFFF : (a == MIN_NEG && b == 32'hFFFF_FFFF) ? {32'b0, a} : sa / sb;
            3'd5: p = (b == 0) ? 64'hFFFF_FFFF : {32'b0, a / b};
            3'd6: p = (b == 0) ? {32'b0, a} : (a == MIN_NEG && b == 32'hFFFF_FFFF) ? 64'd0 : sa % sb;
            default: p = (b == 0) ? {32'b0, a} : {32'b0, a % b};
        endcase
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1; alu_op = 2'b10; funct7 = 7'h01; funct3 = f3; op_a = a; op_b = b;
    endtask

`ifdef RV_MULDIV_EN
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold_chk);
        int stalls, exp_stalls;
        bit done;
        logic [31:0] exp;
        @(negedge clk);
        drive_md(f3, a, b);
        exp_q.push_back(md_model(f3, a, b));
        exp_stalls = (f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) ? 1 : XLEN + 1;
        stalls = 0; done = 0;
        for (int c = 0; c < 3 * XLEN && !done; c++) begin
            #1;
            if (c == 0) check("start_illegal", illegal, 1'b0);
            if (md_done) done = 1;
            else begin
                if (stall) stalls++;
                @(negedge clk);
            end
        end
        valid_in = 1'b0;
        check("md_done_seen", done, 1'b1);
        check("stall_cycles", stalls, exp_stalls);
        check("stall_in_done", stall, 1'b0);
        exp = exp_q.pop_front();
        check("md_result", md_result, exp);
        last_res = exp;
        if (hold_chk) begin
            @(negedge clk); #1;
            check("done_pulse", md_done, 1'b0);
            check("result_hold", md_result, last_res);
        end
    endtask

    task automatic run_flush(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int iter);
        int dones;
        @(negedge clk);
        drive_md(f3, a, b);
        repeat (iter + 1) @(negedge clk);
        #1;
        check("flush_pre_stall", stall, 1'b1);
        flush = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall", stall, 1'b0);
        dones = 0;
        repeat (XLEN + 4) begin
            if (md_done) dones++;
            @(negedge clk); #1;
        end
        check("flush_no_done", dones, 0);
        check("flush_result_hold", md_result, last_res);
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        drive_md(3'd0, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        #1;
        check("mid_mul_stall", stall, 1'b1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_result", md_result, 32'd0);
        check("async_rst_done", md_done, 1'b0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`else
    task automatic run_md_off(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int busy;
        @(negedge clk);
        drive_md(f3, a, b);
        #1;
        check("off_illegal", illegal, 1'b1);
        check("off_ctl", alu_control, C_ADD);
        check("off_md_sel", md_sel, 1'b0);
        busy = 0;
        repeat (6) begin
            if (stall || md_done || md_result != 0) busy++;
            @(negedge clk); #1;
        end
        check("off_quiet", busy, 0);
        valid_in = 1'b0;
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", stall, 1'b0);
        check("reset_done", md_done, 1'b0);
        check("reset_result", md_result, 32'd0);
        rst_n = 1'b1;

        dec_check(2'b10, 3'b000, 7'b0100000, C_SUB, 1'b0, 1'b0);
        dec_check(2'b11, 3'b000, 7'b0100000, C_ADD, 1'b0, 1'b0);
        dec_check(2'b01, 3'b110, 7'b0000000, C_SLTU, 1'b0, 1'b0);
        dec_check(2'b10, 3'b010, 7'b0000010, C_ADD, 1'b1, 1'b0);
        dec_check(2'b11, 3'b101, 7'b0100000, C_SRA, 1'b0, 1'b0);
        dec_check(2'b01, 3'b010, 7'b0000000, C_ADD, 1'b1, 1'b0);
        dec_check(2'b00, 3'b111, 7'b1111111, C_ADD, 1'b0, 1'b0);
        repeat (80) dec_random();

`ifdef RV_MULDIV_EN
        run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        run_md(3'd4, MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        run_md(3'd7, 32'd7, 32'd0, 1'b1);
        run_flush(3'd5, 32'd1000, 32'd7, 10);
        run_md(3'd0, 32'd6, 32'd7, 1'b1);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 24; i++)
            run_md(3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), i[0]);
        run_reset_mid();
        run_md(3'd3, 32'hFFFF_FFFF, 32'h2, 1'b1);
`else
        for (int i = 0; i < 8; i++)
            run_md_off(3'(i), pick_opnd(), pick_opnd());
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised successor to the combinational ALU control decoder. It fully decodes RV32I ALU, immediate and branch operations into a 4-bit ALUcontrol code. It also owns an iterative multiply/divide sequencer (RV32M) that stalls the single-core datapath until its result is ready. It sits in the execute stage between the main control unit and the ALU/writeback mux.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and a power of two.
- CTRL_W, 4: ALUcontrol width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  an instruction is present in execute this cycle.
- flush  in  1  kill the in-flight multiply/divide, synchronous.
- ALUop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7; for I-type only bit 5 is used, and only for shifts.
- op_a, op_b  in  XLEN  rs1/rs2 values for multiply/divide.
- ALUcontrol  out  CTRL_W  ALU operation code.
- illegal  out  1  unsupported ALUop/funct combination.
- md_sel  out  1  the current instruction is multiply/divide, so writeback takes md_result.
- stall  out  1  hold PC and the execute stage.
- md_done  out  1  single-cycle pulse; md_result is valid.
- md_result  out  XLEN  multiply/divide result.

## Operation
- ALUcontrol codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 SLT, 1001 SLTU.
- Decoding is combinational:
  - ALUop 00 → ADD.
  - ALUop 01, by funct3: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU.
  - ALUop 10 and 11, by funct3 with funct7[5] selecting SUB/SRA. For ALUop 11, funct7[5] is ignored except for funct3 101.
- Any unlisted combination → ALUcontrol = ADD and illegal = 1.
- Multiply/divide request ("start"): valid_in & ALUop = 10 & funct7 = 0000001.
  - funct3 000–011 selects MUL, MULH, MULHSU, MULHU.
  - funct3 100–111 selects DIV, DIVU, REM, REMU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL/DIV on start. Operands are latched as magnitudes, and the sign-fix flags are latched with them.
  - MUL: radix-2 shift-add over XLEN iterations, building a 2·XLEN-bit unsigned product.
  - DIV: restoring division over XLEN iterations.
  - MUL/DIV → DONE when the iteration counter reaches XLEN−1.
  - DONE → IDLE unconditionally. Start is not sampled in DONE.
- Sign fix is applied when leaving MUL/DIV.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases go IDLE → DONE directly:
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed most-negative / −1: quotient = dividend, remainder = 0.
- flush in any state other than IDLE → IDLE next edge, no md_done. flush in IDLE blocks start.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - md_result 0; md_done 0.
  - stall 0 in IDLE with no start.
- ALUcontrol, illegal and md_sel are combinational with zero latency; they have no reset dependence.
- stall = (IDLE & start & ~flush) | MUL | DIV, and is 0 in DONE.
- Normal multiply/divide: stall is high for XLEN+1 cycles (the start cycle plus XLEN iterations). DONE is the next cycle: md_done = 1, stall = 0, and the instruction retires at that edge.
- Special case: stall is high for 1 cycle, then DONE.
- md_result is registered and holds its value until the next DONE.
- Back-to-back multiply/divide: the second instruction arrives in IDLE the cycle after DONE and starts normally.
- rst_n low mid-operation clears state immediately (asynchronously); stall drops without waiting for a clock edge.

## Configuration
- RV_MULDIV_EN defined: sequencer present as described.
- RV_MULDIV_EN undefined:
  - funct7 = 0000001 R-type decodes as illegal, with ALUcontrol ADD.
  - stall, md_done, md_sel and md_result are tied to 0.
  - No FSM or registers are instantiated.

## Structure
- Package alu_pkg holds:
  - ALUcontrol code localparams and ALUop codes.
  - FUNCT7_MULDIV = 7'b0000001.
  - The md_state_t enum (IDLE, MUL, DIV, DONE).
- Sub-module muldiv_seq contains the FSM, counter and datapath, and is instantiated only under RV_MULDIV_EN.
- The decoder stays in the top module.

## Test plan
- ALUop 10, funct3 000, funct7 0100000 → ALUcontrol 0110. Same with ALUop 11 → 0010, since funct7 is ignored for ADDI.
- ALUop 01, funct3 110 (BLTU) → 1001. ALUop 10, funct3 010, funct7 0000010 → illegal = 1, ALUcontrol 0010.
- MULH with op_a = 0xFFFFFFFE, op_b = 3 → stall high for 33 cycles; next cycle md_done = 1, md_result = 0xFFFFFFFF.
- DIV with op_a = 0x80000000, op_b = 0xFFFFFFFF → 1 stall cycle, then md_result = 0x80000000. REMU with op_a = 7, op_b = 0 → md_result = 7.
- Start DIVU, assert flush at iteration 10 → IDLE next cycle, stall 0, no md_done. A following MUL 6 × 7 → md_result 42.
- Drop rst_n mid-MUL → stall 0 immediately, md_result 0. Rebuild without RV_MULDIV_EN → MUL flagged illegal, stall never rises.
